// File: rtl/pwm_timer.sv
// Timer/PWM peripheral: prescaled 32-bit up-counter with period wrap, overflow
// interrupt, one-shot mode and four compare-driven PWM outputs.
module pwm_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic [7:0]  raddr_i,
  input  logic        rd_i,
  output logic [31:0] data_o,
  output logic [3:0]  pwm_o,
  output logic        timer_irq
);

  typedef enum logic [5:0] {
    R_CTRL   = 6'h00,
    R_PRESC  = 6'h01,
    R_PERIOD = 6'h02,
    R_CNT    = 6'h03,
    R_STAT   = 6'h04,
    R_CMP0   = 6'h05,
    R_CMP1   = 6'h06,
    R_CMP2   = 6'h07,
    R_CMP3   = 6'h08
  } reg_idx_e;

  logic        en, irq_en, oneshot, ovf;
  logic [3:0]  ch_en;
  logic [15:0] presc, pcnt;
  logic [31:0] period, cnt;
  logic [31:0] cmp [4];

  logic        wr_ctrl, wr_presc, wr_period, wr_cnt, wr_stat;
  logic [3:0]  wr_cmp;
  logic [31:0] wmask, rdata;
  logic [3:0]  pwm_next;
  logic        tick, wrap;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = &{1'b0, waddr_i[1:0], raddr_i[1:0]};

  assign wmask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
  assign tick  = en && (pcnt >= presc);
  assign wrap  = tick && (cnt >= period);
  assign timer_irq = ovf & irq_en;

  always_comb begin
    wr_ctrl   = 1'b0;
    wr_presc  = 1'b0;
    wr_period = 1'b0;
    wr_cnt    = 1'b0;
    wr_stat   = 1'b0;
    wr_cmp    = '0;
    if (we_i) begin
      case (waddr_i[7:2])
        R_CTRL:   wr_ctrl   = 1'b1;
        R_PRESC:  wr_presc  = 1'b1;
        R_PERIOD: wr_period = 1'b1;
        R_CNT:    wr_cnt    = 1'b1;
        R_STAT:   wr_stat   = 1'b1;
        R_CMP0:   wr_cmp[0] = 1'b1;
        R_CMP1:   wr_cmp[1] = 1'b1;
        R_CMP2:   wr_cmp[2] = 1'b1;
        R_CMP3:   wr_cmp[3] = 1'b1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (raddr_i[7:2])
      R_CTRL:   rdata = {24'd0, ch_en, 1'b0, oneshot, irq_en, en};
      R_PRESC:  rdata = {16'd0, presc};
      R_PERIOD: rdata = period;
      R_CNT:    rdata = cnt;
      R_STAT:   rdata = {31'd0, ovf};
      R_CMP0:   rdata = cmp[0];
      R_CMP1:   rdata = cmp[1];
      R_CMP2:   rdata = cmp[2];
      R_CMP3:   rdata = cmp[3];
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    pwm_next = '0;
    for (int unsigned n = 0; n < 4; n++)
      pwm_next[n] = en & ch_en[n] & (cnt < cmp[n]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      oneshot <= 1'b0;
      ch_en   <= '0;
      presc   <= '0;
      pcnt    <= '0;
      period  <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      for (int unsigned n = 0; n < 4; n++) cmp[n] <= '0;
      data_o  <= '0;
      pwm_o   <= '0;
    end else begin
      if (!en || pcnt >= presc) pcnt <= '0;
      else                      pcnt <= pcnt + 16'd1;

      // A CTRL write overrides the one-shot auto-disable in the same cycle.
      if (wr_ctrl) begin
        if (sel_i[0]) begin
          en      <= data_i[0];
          irq_en  <= data_i[1];
          oneshot <= data_i[2];
          ch_en   <= data_i[7:4];
        end
      end else if (wrap && oneshot) begin
        en <= 1'b0;
      end

      if (wr_presc)  presc  <= (presc & ~wmask[15:0]) | (data_i[15:0] & wmask[15:0]);
      if (wr_period) period <= (period & ~wmask) | (data_i & wmask);

      if (wr_cnt)    cnt <= (cnt & ~wmask) | (data_i & wmask);
      else if (wrap) cnt <= '0;
      else if (tick) cnt <= cnt + 32'd1;

      if (wrap)                                  ovf <= 1'b1;
      else if (wr_stat && sel_i[0] && data_i[0]) ovf <= 1'b0;

      for (int unsigned n = 0; n < 4; n++)
        if (wr_cmp[n]) cmp[n] <= (cmp[n] & ~wmask) | (data_i & wmask);

      if (rd_i) data_o <= rdata;
      pwm_o <= pwm_next;
    end
  end

endmodule

// File: tb/tb_pwm_timer.sv
// Directed-vector bench for pwm_timer with hand-computed expectations.
module tb_pwm_timer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  waddr_i;
  logic [31:0] data_i;
  logic [3:0]  sel_i;
  logic        we_i;
  logic [7:0]  raddr_i;
  logic        rd_i;
  logic [31:0] data_o;
  logic [3:0]  pwm_o;
  logic        timer_irq;

  int vectors = 0;
  int errors  = 0;
  int others_bad = 0;

  pwm_timer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .waddr_i   (waddr_i),
    .data_i    (data_i),
    .sel_i     (sel_i),
    .we_i      (we_i),
    .raddr_i   (raddr_i),
    .rd_i      (rd_i),
    .data_o    (data_o),
    .pwm_o     (pwm_o),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    waddr_i = a; data_i = d; sel_i = s; we_i = 1'b1;
    @(negedge clk);
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    raddr_i = a; rd_i = 1'b1;
    @(negedge clk);
    rd_i = 1'b0;
    d = data_o;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_len(input logic lvl, output int len);
    len = 0;
    while (pwm_o[0] === lvl && len < 100) begin
      if (pwm_o[3:1] !== 3'b000) others_bad++;
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] d;
    int n, hi1, lo1, hi2, cnt_bad;

    rst_n = 1'b0; waddr_i = '0; data_i = '0; sel_i = '0; we_i = 1'b0;
    raddr_i = '0; rd_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and readback
    check("rst_pwm", {28'd0, pwm_o}, 32'd0);
    check("rst_irq", {31'd0, timer_irq}, 32'd0);
    check("rst_data", data_o, 32'd0);
    for (int a = 0; a <= 8'h20; a += 4) begin
      rd(8'(a), d);
      check($sformatf("rst_read_%02h", a), d, 32'd0);
    end
    wr(8'h1C, 32'hA5A5A5A5, 4'b0101);
    rd(8'h1C, d);  check("cmp2_partial", d, 32'h00A500A5);
    wr(8'h24, 32'hFFFFFFFF, 4'hF);
    rd(8'h24, d);  check("unmapped_24", d, 32'd0);

    // Basic count: CNT sampled every cycle reads 0,1,2,3,0
    wr(8'h04, 32'd0, 4'hF);
    wr(8'h08, 32'd3, 4'hF);
    wr(8'h00, 32'h03, 4'hF);
    raddr_i = 8'h0C; rd_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("count_seq_%0d", k), data_o, 32'(k % 4));
    end
    rd_i = 1'b0;
    check("count_irq", {31'd0, timer_irq}, 32'd1);
    wr(8'h00, 32'h02, 4'hF);
    rd(8'h10, d);  check("count_ovf", d, 32'd1);
    wr(8'h10, 32'd0, 4'hF);
    check("stat_w0_keep", {31'd0, timer_irq}, 32'd1);
    wr(8'h10, 32'd1, 4'hF);
    check("stat_w1c_irq", {31'd0, timer_irq}, 32'd0);

    // Prescaler and PWM: PRESC=2, PERIOD=9, CMP0=5 -> 15 high / 15 low
    do_reset();
    wr(8'h04, 32'd2, 4'hF);
    wr(8'h08, 32'd9, 4'hF);
    wr(8'h14, 32'd5, 4'hF);
    wr(8'h00, 32'h11, 4'hF);
    n = 0;
    while (pwm_o[0] !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    run_len(1'b1, hi1);
    run_len(1'b0, lo1);
    run_len(1'b1, hi2);
    check("pwm0_high1", 32'(hi1), 32'd15);
    check("pwm0_low", 32'(lo1), 32'd15);
    check("pwm0_high2", 32'(hi2), 32'd15);
    check("pwm_others_low", 32'(others_bad), 32'd0);

    // One-shot: PERIOD=5 wraps after 6 ticks then stops
    do_reset();
    wr(8'h08, 32'd5, 4'hF);
    wr(8'h00, 32'h07, 4'hF);
    repeat (8) @(negedge clk);
    rd(8'h00, d);  check("oneshot_ctrl", d, 32'h06);
    rd(8'h0C, d);  check("oneshot_cnt", d, 32'd0);
    rd(8'h10, d);  check("oneshot_ovf", d, 32'd1);

    // Collision: W1C on the wrap edge (CTRL edge P0, wrap at P4)
    do_reset();
    wr(8'h08, 32'd3, 4'hF);
    wr(8'h00, 32'h01, 4'hF);
    repeat (3) @(negedge clk);
    wr(8'h10, 32'd1, 4'hF);
    rd(8'h10, d);  check("ovf_set_beats_clr", d, 32'd1);
    // CNT write during a tick (PRESC=0 ticks every cycle)
    wr(8'h0C, 32'h100, 4'hF);
    rd(8'h0C, d);  check("cnt_write_beats_tick", d, 32'h100);
    wr(8'h00, 32'h00, 4'hF);
    wr(8'h0C, 32'h55, 4'hF);
    waddr_i = 8'h0C; data_i = 32'hAA; sel_i = 4'hF; we_i = 1'b1;
    raddr_i = 8'h0C; rd_i = 1'b1;
    @(negedge clk);
    we_i = 1'b0; rd_i = 1'b0;
    check("rw_same_cycle_old", data_o, 32'h55);
    rd(8'h0C, d);  check("rw_same_cycle_new", d, 32'hAA);
    wr(8'h0C, 32'h12345678, 4'b0010);
    rd(8'h0C, d);  check("cnt_partial_merge", d, 32'h000056AA);

    // Edge: CMP1=0, PERIOD=max -> pwm1 never high
    do_reset();
    wr(8'h08, 32'hFFFFFFFF, 4'hF);
    wr(8'h18, 32'd0, 4'hF);
    wr(8'h00, 32'h21, 4'hF);
    cnt_bad = 0;
    repeat (20) begin @(negedge clk); if (pwm_o[1] !== 1'b0) cnt_bad++; end
    check("cmp_zero_low", 32'(cnt_bad), 32'd0);

    // Edge: CMP1=max, PERIOD=7 -> pwm1 always high, across several wraps
    do_reset();
    wr(8'h08, 32'd7, 4'hF);
    wr(8'h18, 32'hFFFFFFFF, 4'hF);
    wr(8'h00, 32'h21, 4'hF);
    @(negedge clk);
    cnt_bad = 0;
    repeat (40) begin if (pwm_o[1] !== 1'b1) cnt_bad++; @(negedge clk); end
    check("cmp_max_high", 32'(cnt_bad), 32'd0);

    // Edge: lowering PERIOD below CNT wraps on the next tick (PRESC=3)
    do_reset();
    wr(8'h04, 32'd3, 4'hF);
    wr(8'h0C, 32'd20, 4'hF);
    wr(8'h08, 32'd10, 4'hF);
    wr(8'h00, 32'h01, 4'hF);
    rd(8'h0C, d);  check("period_low_pre", d, 32'd20);
    repeat (3) @(negedge clk);
    rd(8'h0C, d);  check("period_low_wrap", d, 32'd0);
    rd(8'h10, d);  check("period_low_ovf", d, 32'd1);

    // Asynchronous reset mid-count
    wr(8'h14, 32'hFFFFFFFF, 4'hF);
    wr(8'h00, 32'h13, 4'hF);
    @(negedge clk);
    check("pre_rst_pwm0", {31'd0, pwm_o[0]}, 32'd1);
    check("pre_rst_irq", {31'd0, timer_irq}, 32'd1);
    rd(8'h08, d);  check("pre_rst_data", d, 32'd10);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data", data_o, 32'd0);
    check("async_rst_pwm", {28'd0, pwm_o}, 32'd0);
    check("async_rst_irq", {31'd0, timer_irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(8'h0C, d);  check("post_rst_cnt", d, 32'd0);
    rd(8'h00, d);  check("post_rst_ctrl", d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
